// File: rtl/float_to_fixed_pkg.sv
// Shared floating-point format package: format descriptor, precision lookup
// and value classes used by the float_to_fixed / add / log2 family.
package float_to_fixed_pkg;

    typedef struct packed {
        int exp_bits;
        int mant_bits;
        int bias;
    } fp_fmt_t;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NORMAL = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } fp_class_t;

    // Anything other than "SINGLE" selects the half-precision layout.
    function automatic fp_fmt_t fmt_of(input logic [47:0] precision);
        fp_fmt_t f;
        if (precision == "SINGLE") begin
            f.exp_bits  = 32'sd8;
            f.mant_bits = 32'sd23;
            f.bias      = 32'sd127;
        end else begin
            f.exp_bits  = 32'sd5;
            f.mant_bits = 32'sd10;
            f.bias      = 32'sd15;
        end
        return f;
    endfunction

endpackage

// File: rtl/float_to_fixed_unpack.sv
// Combinational float unpack: sign, biased exponent, significand with the
// hidden bit restored, and value class. Subnormals are flushed to zero.
module float_unpack
    import float_to_fixed_pkg::*;
#(
    parameter int EXP_W  = 5,
    parameter int MANT_W = 10
) (
    input  logic [EXP_W+MANT_W:0] a,
    output logic                  sign,
    output logic [EXP_W-1:0]      expo,
    output logic [MANT_W:0]       sig,
    output fp_class_t             cls
);

    // Field split and classification.
    always_comb begin
        sign = a[EXP_W+MANT_W];
        expo = a[EXP_W+MANT_W-1:MANT_W];
        sig  = {1'b0, a[MANT_W-1:0]};
        cls  = NORMAL;
        if (expo == {EXP_W{1'b0}}) begin
            sig = {(MANT_W+1){1'b0}};
            cls = ZERO;
        end else if (&expo) begin
            cls = (a[MANT_W-1:0] != {MANT_W{1'b0}}) ? NAN : INF;
        end else begin
            sig = {1'b1, a[MANT_W-1:0]};
        end
    end

endmodule

// File: rtl/float_to_fixed.sv
// Three-stage float -> signed fixed-point converter with saturation flags and
// a saturating event counter. Define FLOAT_TO_FIXED_ROUND_EN for
// round-to-nearest-even; otherwise the magnitude is truncated toward zero.
module float_to_fixed
    import float_to_fixed_pkg::*;
#(
    parameter int          BITS      = 16,
    parameter logic [47:0] PRECISION = 48'("HALF"),
    parameter int          OUT_BITS  = 16,
    parameter int          FRAC_BITS = 10,
    parameter int          CNT_BITS  = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    input  logic [BITS-1:0]     a,
    input  logic                cnt_clear,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] c,
    output logic                overflow,
    output logic                invalid,
    output logic [CNT_BITS-1:0] sat_count
);

    localparam fp_fmt_t FMT    = fmt_of(PRECISION);
    localparam int      EXP_W  = FMT.exp_bits;
    localparam int      MANT_W = FMT.mant_bits;
    localparam int      BIAS   = FMT.bias;
    localparam int      RW     = MANT_W + 1;
    localparam int      MW     = OUT_BITS + 2;
    localparam int      SHW    = 16;

    localparam logic signed [SHW-1:0] SHIFT_OFS = SHW'(FRAC_BITS - MANT_W - BIAS);
    // exp - bias >= OUT_BITS - FRAC_BITS expressed in terms of shift
    localparam logic signed [SHW-1:0] OVF_SHIFT = SHW'(OUT_BITS - MANT_W);
    localparam logic [SHW-1:0]        RW_L      = SHW'(RW);
    localparam logic [MW-1:0]         LIM_POS   = {{(MW-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
    localparam logic [MW-1:0]         LIM_NEG   = {{(MW-OUT_BITS){1'b0}}, 1'b1, {(OUT_BITS-1){1'b0}}};
    localparam logic [OUT_BITS-1:0]   MAX_POS   = {1'b0, {(OUT_BITS-1){1'b1}}};
    localparam logic [OUT_BITS-1:0]   MIN_NEG   = {1'b1, {(OUT_BITS-1){1'b0}}};
    localparam logic [OUT_BITS-1:0]   ONE_O     = {{(OUT_BITS-1){1'b0}}, 1'b1};

    logic                  u_sign_s;
    logic [EXP_W-1:0]      u_exp_s;
    logic [RW-1:0]         u_sig_s;
    fp_class_t             u_cls_s;
    logic signed [SHW-1:0] shift_s;

    float_unpack #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_unpack (
        .a    (a),
        .sign (u_sign_s),
        .expo (u_exp_s),
        .sig  (u_sig_s),
        .cls  (u_cls_s)
    );

    assign shift_s = $signed({{(SHW-EXP_W){1'b0}}, u_exp_s}) + SHIFT_OFS;

    logic                  s1_valid_r, s1_sign_r;
    fp_class_t             s1_cls_r;
    logic [RW-1:0]         s1_sig_r;
    logic signed [SHW-1:0] s1_shift_r;

    // Stage 1 register: classified operand and alignment shift.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_r <= 1'b0;
            s1_sign_r  <= 1'b0;
            s1_cls_r   <= ZERO;
            s1_sig_r   <= {RW{1'b0}};
            s1_shift_r <= {SHW{1'b0}};
        end else begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_sign_r  <= u_sign_s;
                s1_cls_r   <= u_cls_s;
                s1_sig_r   <= u_sig_s;
                s1_shift_r <= shift_s;
            end
        end
    end

    logic [MW-1:0]  al_mag_s;
    logic           al_ovf_s;
    logic [SHW-1:0] rsh_s;
`ifdef FLOAT_TO_FIXED_ROUND_EN
    logic           al_guard_s, al_sticky_s;
`endif

    // Stage 2 alignment of the significand into fixed-point units.
    always_comb begin
        al_mag_s = {MW{1'b0}};
        al_ovf_s = 1'b0;
        rsh_s    = {SHW{1'b0}};
`ifdef FLOAT_TO_FIXED_ROUND_EN
        al_guard_s  = 1'b0;
        al_sticky_s = 1'b0;
`endif
        if (s1_cls_r == INF) begin
            al_ovf_s = 1'b1;
        end else if (s1_cls_r != NORMAL) begin
            al_mag_s = {MW{1'b0}};
        end else if (s1_shift_r >= OVF_SHIFT) begin
            al_ovf_s = 1'b1;
        end else if (!s1_shift_r[SHW-1]) begin
            al_mag_s = MW'({{MW{1'b0}}, s1_sig_r} << s1_shift_r);
        end else begin
            rsh_s = -s1_shift_r;
            if (rsh_s > RW_L) begin
                al_mag_s = {MW{1'b0}};
`ifdef FLOAT_TO_FIXED_ROUND_EN
                al_sticky_s = |s1_sig_r;
`endif
            end else begin
                al_mag_s = MW'(s1_sig_r >> rsh_s);
`ifdef FLOAT_TO_FIXED_ROUND_EN
                for (int i = 0; i < RW; i++) begin
                    if (i == int'(rsh_s) - 1) begin
                        al_guard_s = s1_sig_r[i];
                    end else if (i < int'(rsh_s) - 1) begin
                        al_sticky_s = al_sticky_s | s1_sig_r[i];
                    end else begin
                        al_sticky_s = al_sticky_s;
                    end
                end
`endif
            end
        end
    end

    logic          s2_valid_r, s2_sign_r, s2_ovf_r;
    fp_class_t     s2_cls_r;
    logic [MW-1:0] s2_mag_r;
`ifdef FLOAT_TO_FIXED_ROUND_EN
    logic          s2_guard_r, s2_sticky_r;
`endif

    // Stage 2 register: aligned magnitude and early-overflow flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid_r  <= 1'b0;
            s2_sign_r   <= 1'b0;
            s2_ovf_r    <= 1'b0;
            s2_cls_r    <= ZERO;
            s2_mag_r    <= {MW{1'b0}};
`ifdef FLOAT_TO_FIXED_ROUND_EN
            s2_guard_r  <= 1'b0;
            s2_sticky_r <= 1'b0;
`endif
        end else begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_sign_r   <= s1_sign_r;
                s2_ovf_r    <= al_ovf_s;
                s2_cls_r    <= s1_cls_r;
                s2_mag_r    <= al_mag_s;
`ifdef FLOAT_TO_FIXED_ROUND_EN
                s2_guard_r  <= al_guard_s;
                s2_sticky_r <= al_sticky_s;
`endif
            end
        end
    end

    logic [MW-1:0]       rnd_mag_s;
    logic [OUT_BITS-1:0] res_c_s;
    logic                res_ovf_s, res_inv_s;

`ifdef FLOAT_TO_FIXED_ROUND_EN
    assign rnd_mag_s = s2_mag_r + {{(MW-1){1'b0}}, s2_guard_r & (s2_sticky_r | s2_mag_r[0])};
`else
    assign rnd_mag_s = s2_mag_r;
`endif

    // Stage 3 saturation and two's-complement negation.
    always_comb begin
        res_c_s   = {OUT_BITS{1'b0}};
        res_ovf_s = 1'b0;
        res_inv_s = 1'b0;
        if (s2_cls_r == NAN) begin
            res_inv_s = 1'b1;
        end else if (s2_ovf_r || (!s2_sign_r && (rnd_mag_s > LIM_POS)) ||
                     (s2_sign_r && (rnd_mag_s > LIM_NEG))) begin
            res_ovf_s = 1'b1;
            res_c_s   = s2_sign_r ? MIN_NEG : MAX_POS;
        end else if (s2_sign_r) begin
            res_c_s = ~rnd_mag_s[OUT_BITS-1:0] + ONE_O;
        end else begin
            res_c_s = rnd_mag_s[OUT_BITS-1:0];
        end
    end

    // Output register; data holds while no sample completes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            c         <= {OUT_BITS{1'b0}};
            overflow  <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            out_valid <= s2_valid_r;
            if (s2_valid_r) begin
                c        <= res_c_s;
                overflow <= res_ovf_s;
                invalid  <= res_inv_s;
            end
        end
    end

    // Saturation event counter; counts the presented output flags, clear wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_count <= {CNT_BITS{1'b0}};
        end else if (cnt_clear) begin
            sat_count <= {CNT_BITS{1'b0}};
        end else if (out_valid && (overflow || invalid) && !(&sat_count)) begin
            sat_count <= sat_count + {{(CNT_BITS-1){1'b0}}, 1'b1};
        end else begin
            sat_count <= sat_count;
        end
    end

endmodule

// File: tb/tb_float_to_fixed.sv
// Bench for float_to_fixed (HALF, Q6.10, 2-bit counter): directed vector table,
// reset/counter sequences and random stream against a real-arithmetic model.
module tb_float_to_fixed;

    logic        clk = 1'b0;
    logic        rstn, in_valid, cnt_clear;
    logic [15:0] a;
    logic        out_valid, overflow, invalid;
    logic [15:0] c;
    logic [1:0]  sat_count;

    always #5 clk = ~clk;

    float_to_fixed #(.OUT_BITS(16), .FRAC_BITS(10), .CNT_BITS(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .a         (a),
        .cnt_clear (cnt_clear),
        .out_valid (out_valid),
        .c         (c),
        .overflow  (overflow),
        .invalid   (invalid),
        .sat_count (sat_count)
    );

    typedef struct { logic [15:0] a; logic [15:0] c; logic ovf; logic inv; } vec_t;
    typedef struct { int due; logic [15:0] c; logic ovf; logic inv; } exp_t;

    exp_t        sb[$];
    vec_t        tbl[11];
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    logic [15:0] last_c;
    logic        last_ovf, last_inv, ev, evt;
    int          sat_m;
    exp_t        e;
    logic [15:0] rx, rc;
    logic        ro, ri;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint want);
        checks++;
        if (act == want) passes++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, want, cyc);
    endtask

    // Reference: decode the half float as a real value scaled by 2^10.
    function automatic void model(input logic [15:0] x, output logic [15:0] ec,
                                  output logic eo, output logic ei);
        int     ex, m, ip;
        real    v, fr;
        longint s;
        ex = int'(x[14:10]);
        m  = int'(x[9:0]);
        ec = 16'h0000; eo = 1'b0; ei = 1'b0;
        if (ex == 31) begin
            if (m != 0) ei = 1'b1;
            else begin
                eo = 1'b1;
                ec = x[15] ? 16'h8000 : 16'h7FFF;
            end
        end else if (ex != 0) begin
            v = 1024.0 + m;
            for (int i = 15; i < ex; i++) v = v * 2.0;
            for (int i = ex; i < 15; i++) v = v / 2.0;
            ip = $rtoi(v);
            fr = v - ip;
`ifdef FLOAT_TO_FIXED_ROUND_EN
            if (fr > 0.5 || (fr == 0.5 && (ip % 2) == 1)) ip = ip + 1;
`endif
            s = x[15] ? -longint'(ip) : longint'(ip);
            if (s > 32767) begin eo = 1'b1; ec = 16'h7FFF; end
            else if (s < -32768) begin eo = 1'b1; ec = 16'h8000; end
            else ec = 16'(s);
        end
    endfunction

    task automatic step(input logic v, input logic [15:0] val, input logic clr,
                        input logic [15:0] ec, input logic eo, input logic ei);
        @(posedge clk);
        #1;
        in_valid  = v;
        a         = val;
        cnt_clear = clr;
        if (v) sb.push_back('{due: cyc + 3, c: ec, ovf: eo, inv: ei});
    endtask

    task automatic idle(input logic clr);
        step(1'b0, 16'h0000, clr, 16'h0000, 1'b0, 1'b0);
    endtask

    // Cycle monitor: exact-latency output check, hold check, counter model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                sb.delete();
                last_c = 16'h0000; last_ovf = 1'b0; last_inv = 1'b0; sat_m = 0;
                check("rst_out_valid", out_valid, 0);
                check("rst_c", c, 0);
                check("rst_overflow", overflow, 0);
                check("rst_invalid", invalid, 0);
                check("rst_sat_count", sat_count, 0);
            end else begin
                ev = (sb.size() > 0) && (sb[0].due == cyc);
                check("out_valid", out_valid, ev);
                if (ev) begin
                    e = sb.pop_front();
                    last_c = e.c; last_ovf = e.ovf; last_inv = e.inv;
                end
                check("c", c, last_c);
                check("overflow", overflow, last_ovf);
                check("invalid", invalid, last_inv);
                check("sat_count", sat_count, sat_m);
                evt = ev && (last_ovf || last_inv);
                if (cnt_clear) sat_m = 0;
                else if (evt && sat_m < 3) sat_m = sat_m + 1;
            end
        end
    end

    initial begin
        rstn = 1'b0; in_valid = 1'b0; a = 16'h0000; cnt_clear = 1'b0;
        tbl[0]  = '{16'h3C00, 16'h0400, 1'b0, 1'b0};
        tbl[1]  = '{16'hC100, 16'hF600, 1'b0, 1'b0};
        tbl[2]  = '{16'h5100, 16'h7FFF, 1'b1, 1'b0};
        tbl[3]  = '{16'hD000, 16'h8000, 1'b0, 1'b0};
        tbl[4]  = '{16'hFC00, 16'h8000, 1'b1, 1'b0};
        tbl[5]  = '{16'h7E00, 16'h0000, 1'b0, 1'b1};
        tbl[6]  = '{16'h0001, 16'h0000, 1'b0, 1'b0};
        tbl[7]  = '{16'h8000, 16'h0000, 1'b0, 1'b0};
`ifdef FLOAT_TO_FIXED_ROUND_EN
        tbl[8]  = '{16'h3803, 16'h0202, 1'b0, 1'b0};
`else
        tbl[8]  = '{16'h3803, 16'h0201, 1'b0, 1'b0};
`endif
        tbl[9]  = '{16'h3801, 16'h0200, 1'b0, 1'b0};
        tbl[10] = '{16'h7C00, 16'h7FFF, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Back-to-back directed vectors; 4 flagged events saturate the counter.
        for (int i = 0; i < 11; i++)
            step(1'b1, tbl[i].a, 1'b0, tbl[i].c, tbl[i].ovf, tbl[i].inv);
        repeat (5) idle(1'b0);
        check("sat_saturated", sat_count, 3);

        // Clear lands in the cycle the overflow result is presented.
        step(1'b1, 16'h5100, 1'b0, 16'h7FFF, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        check("clear_wins", sat_count, 0);

        // Reset with two samples in flight.
        step(1'b1, 16'h3C00, 1'b0, 16'h0400, 1'b0, 1'b0);
        step(1'b1, 16'hC100, 1'b0, 16'hF600, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        check("post_rst_c", c, 0);
        repeat (5) idle(1'b0);

        // Random stream with sporadic bubbles and clears.
        for (int i = 0; i < 400; i++) begin
            rx = 16'($urandom);
            model(rx, rc, ro, ri);
            step($urandom_range(0, 3) != 0, rx, $urandom_range(0, 15) == 0, rc, ro, ri);
        end
        repeat (6) idle(1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
